// File: rtl/mmss_updown_timer.sv
// mmss_updown_timer
// MM:SS stopwatch / countdown timer with four BCD digits, running in a
// single clock domain. A prescaler produces one count step every TICK_DIV
// cycles while running. The timer supports start/stop, clear, and preload
// commands, and signals up-count wrap and down-count expiry.
//
// Parameters:
//   TICK_DIV      clk cycles per count step (>= 2)
//   MAX_MIN_TENS  upper limit of the minutes-tens digit (0..9)
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous reset, active-low
//   start     pulse: begin/resume counting (ignored for a zero countdown)
//   stop      pulse: pause counting, prescaler keeps its partial count
//   clear     pulse: zero the count and prescaler, go idle
//   load      pulse: preload count from load_bcd if all digits are valid
//   load_bcd  preload value {min tens, min ones, sec tens, sec ones}
//   mode      0 = count up, 1 = count down (sampled at each step)
//   bcd       current count {min tens, min ones, sec tens, sec ones}
//   running   high while counting
//   tick      one-cycle pulse on every count step
//   wrap      one-cycle pulse when the up-count rolls max -> 00:00
//   done      one-cycle pulse when the down-count reaches 00:00
//   expired   high after the countdown has finished, until clear/load
module mmss_updown_timer #(
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned MAX_MIN_TENS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_bcd,
    input  logic        mode,
    output logic [15:0] bcd,
    output logic        running,
    output logic        tick,
    output logic        wrap,
    output logic        done,
    output logic        expired
);

    localparam int unsigned PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    MT       = 4'(MAX_MIN_TENS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    state_t        state, stateNext;
    logic [PW-1:0] prescaler, prescalerNext;
    logic [15:0]   bcdNext;
    logic          tickNext, wrapNext, doneNext;

    logic [15:0]   upBcd, downBcd;
    logic          upWrap, downZero;
    logic          validLoad, isZero, stepNow;

    assign validLoad = load &&
                       (load_bcd[3:0]   <= 4'd9) &&
                       (load_bcd[7:4]   <= 4'd5) &&
                       (load_bcd[11:8]  <= 4'd9) &&
                       (load_bcd[15:12] <= MT);
    assign isZero    = (bcd == '0);

    // A step is only taken when no command of higher priority is present.
    assign stepNow   = (state == RUN) && (prescaler == PRE_LAST) &&
                       !clear && !validLoad && !stop && !start;

    // BCD increment with carry chain; wrap flags the max -> 00:00 rollover.
    always_comb begin
        upBcd  = bcd;
        upWrap = 1'b0;
        if (bcd[3:0] != 4'd9) begin
            upBcd[3:0] = bcd[3:0] + 4'd1;
        end else begin
            upBcd[3:0] = '0;
            if (bcd[7:4] != 4'd5) begin
                upBcd[7:4] = bcd[7:4] + 4'd1;
            end else begin
                upBcd[7:4] = '0;
                if (bcd[11:8] != 4'd9) begin
                    upBcd[11:8] = bcd[11:8] + 4'd1;
                end else begin
                    upBcd[11:8] = '0;
                    if (bcd[15:12] != MT) begin
                        upBcd[15:12] = bcd[15:12] + 4'd1;
                    end else begin
                        upBcd[15:12] = '0;
                        upWrap       = 1'b1;
                    end
                end
            end
        end
    end

    // BCD decrement with borrow chain. Decrementing 00:00 (mode flipped
    // while running at zero) rolls to the maximum count.
    always_comb begin
        downBcd = bcd;
        if (bcd[3:0] != 4'd0) begin
            downBcd[3:0] = bcd[3:0] - 4'd1;
        end else begin
            downBcd[3:0] = 4'd9;
            if (bcd[7:4] != 4'd0) begin
                downBcd[7:4] = bcd[7:4] - 4'd1;
            end else begin
                downBcd[7:4] = 4'd5;
                if (bcd[11:8] != 4'd0) begin
                    downBcd[11:8] = bcd[11:8] - 4'd1;
                end else begin
                    downBcd[11:8] = 4'd9;
                    if (bcd[15:12] != 4'd0) begin
                        downBcd[15:12] = bcd[15:12] - 4'd1;
                    end else begin
                        downBcd[15:12] = MT;
                    end
                end
            end
        end
    end

    assign downZero = (downBcd == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic, highest-priority command first
    always_comb begin
        stateNext = state;
        if (clear || validLoad) begin
            stateNext = IDLE;
        end else if (stop) begin
            if (state == RUN) begin
                stateNext = IDLE;
            end
        end else if (start) begin
            if ((state == IDLE) && !(mode && isZero)) begin
                stateNext = RUN;
            end
        end else if (stepNow && mode && downZero) begin
            stateNext = EXPIRED;
        end
    end

    // State-decoded outputs
    always_comb begin
        running = (state == RUN);
        expired = (state == EXPIRED);
    end

    // Count and prescaler datapath. stop/start hold the prescaler, so a
    // resumed run finishes the interrupted step period exactly.
    always_comb begin
        prescalerNext = prescaler;
        bcdNext       = bcd;
        tickNext      = 1'b0;
        wrapNext      = 1'b0;
        doneNext      = 1'b0;
        if (clear) begin
            prescalerNext = '0;
            bcdNext       = '0;
        end else if (validLoad) begin
            prescalerNext = '0;
            bcdNext       = load_bcd;
        end else if (stop || start) begin
            prescalerNext = prescaler;
        end else if (stepNow) begin
            prescalerNext = '0;
            tickNext      = 1'b1;
            if (mode) begin
                bcdNext  = downBcd;
                doneNext = downZero;
            end else begin
                bcdNext  = upBcd;
                wrapNext = upWrap;
            end
        end else if (state == RUN) begin
            prescalerNext = prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            bcd       <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            prescaler <= prescalerNext;
            bcd       <= bcdNext;
            tick      <= tickNext;
            wrap      <= wrapNext;
            done      <= doneNext;
        end
    end

endmodule

// File: tb/tb_mmss_updown_timer.sv
// tb_mmss_updown_timer
// Directed self-checking bench for mmss_updown_timer with TICK_DIV = 4 and
// MAX_MIN_TENS = 5. Inputs change and outputs are sampled 1 ns after each
// rising clock edge.
module tb_mmss_updown_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_bcd = '0;
    logic        mode = 1'b0;
    logic [15:0] bcd;
    logic        running, tick, wrap, done, expired;

    int checks = 0;
    int passes = 0;

    mmss_updown_timer #(
        .TICK_DIV     (4),
        .MAX_MIN_TENS (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_bcd (load_bcd),
        .mode     (mode),
        .bcd      (bcd),
        .running  (running),
        .tick     (tick),
        .wrap     (wrap),
        .done     (done),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Seconds count -> expected {min tens, min ones, sec tens, sec ones}
    function automatic logic [15:0] toBcd(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        advance();
        advance();
        checks++;
        if ({bcd, running, tick, wrap, done, expired} !== 21'd0)
            $display("FAIL reset_state: got bcd=%h run=%b tick=%b wrap=%b done=%b exp=%b expected all zero",
                     bcd, running, tick, wrap, done, expired);
        else passes++;
        rst_n = 1'b1;
        advance();
        checks++;
        if (running !== 1'b0 || bcd !== 16'h0000)
            $display("FAIL reset_release_idle: got run=%b bcd=%h expected 0 0000", running, bcd);
        else passes++;
    endtask

    task automatic test_count_up();
        mode  = 1'b0;
        start = 1'b1;
        advance();
        start = 1'b0;
        checks++;
        if (running !== 1'b1) $display("FAIL up_running: got %b expected 1", running);
        else passes++;
        for (int k = 1; k <= 60; k++) begin
            for (int j = 0; j < 3; j++) begin
                advance();
                checks++;
                if (tick !== 1'b0) $display("FAIL up_no_tick step=%0d: got %b expected 0", k, tick);
                else passes++;
            end
            advance();
            checks++;
            if (tick !== 1'b1 || bcd !== toBcd(k) || wrap !== 1'b0)
                $display("FAIL up_step %0d: got tick=%b bcd=%h wrap=%b expected 1 %h 0",
                         k, tick, bcd, wrap, toBcd(k));
            else passes++;
        end
        checks++;
        if (bcd !== 16'h0100) $display("FAIL up_reach_0100: got %h expected 0100", bcd);
        else passes++;
        clear = 1'b1;
        advance();
        clear = 1'b0;
        checks++;
        if (bcd !== 16'h0000 || running !== 1'b0)
            $display("FAIL up_clear: got bcd=%h run=%b expected 0000 0", bcd, running);
        else passes++;
    endtask

    task automatic test_wrap();
        mode     = 1'b0;
        load_bcd = 16'h5958;
        load     = 1'b1;
        advance();
        load     = 1'b0;
        checks++;
        if (bcd !== 16'h5958 || running !== 1'b0)
            $display("FAIL wrap_load: got bcd=%h run=%b expected 5958 0", bcd, running);
        else passes++;
        start = 1'b1;
        advance();
        start = 1'b0;
        repeat (4) advance();
        checks++;
        if (bcd !== 16'h5959 || tick !== 1'b1 || wrap !== 1'b0)
            $display("FAIL wrap_5959: got bcd=%h tick=%b wrap=%b expected 5959 1 0", bcd, tick, wrap);
        else passes++;
        repeat (4) advance();
        checks++;
        if (bcd !== 16'h0000 || tick !== 1'b1 || wrap !== 1'b1 || running !== 1'b1)
            $display("FAIL wrap_rollover: got bcd=%h tick=%b wrap=%b run=%b expected 0000 1 1 1",
                     bcd, tick, wrap, running);
        else passes++;
        advance();
        checks++;
        if (wrap !== 1'b0 || tick !== 1'b0 || running !== 1'b1)
            $display("FAIL wrap_one_cycle: got wrap=%b tick=%b run=%b expected 0 0 1", wrap, tick, running);
        else passes++;
        clear = 1'b1;
        advance();
        clear = 1'b0;
    endtask

    task automatic test_countdown();
        mode     = 1'b1;
        load_bcd = 16'h0100;
        load     = 1'b1;
        advance();
        load     = 1'b0;
        start    = 1'b1;
        advance();
        start    = 1'b0;
        for (int k = 1; k <= 59; k++) begin
            repeat (4) advance();
            checks++;
            if (tick !== 1'b1 || bcd !== toBcd(60 - k) || done !== 1'b0 || running !== 1'b1)
                $display("FAIL down_step %0d: got tick=%b bcd=%h done=%b run=%b expected 1 %h 0 1",
                         k, tick, bcd, done, running, toBcd(60 - k));
            else passes++;
        end
        repeat (4) advance();
        checks++;
        if (bcd !== 16'h0000 || done !== 1'b1 || tick !== 1'b1 || expired !== 1'b1 || running !== 1'b0)
            $display("FAIL down_done: got bcd=%h done=%b tick=%b exp=%b run=%b expected 0000 1 1 1 0",
                     bcd, done, tick, expired, running);
        else passes++;
        advance();
        checks++;
        if (done !== 1'b0 || expired !== 1'b1)
            $display("FAIL down_done_pulse: got done=%b exp=%b expected 0 1", done, expired);
        else passes++;
        start = 1'b1;
        advance();
        start = 1'b0;
        repeat (8) advance();
        checks++;
        if (running !== 1'b0 || expired !== 1'b1 || bcd !== 16'h0000 || tick !== 1'b0)
            $display("FAIL expired_start_ignored: got run=%b exp=%b bcd=%h tick=%b expected 0 1 0000 0",
                     running, expired, bcd, tick);
        else passes++;
        clear = 1'b1;
        advance();
        clear = 1'b0;
        checks++;
        if (expired !== 1'b0 || running !== 1'b0 || bcd !== 16'h0000)
            $display("FAIL expired_clear: got exp=%b run=%b bcd=%h expected 0 0 0000", expired, running, bcd);
        else passes++;
        mode = 1'b0;
    endtask

    task automatic test_stop_resume();
        logic sawTick;
        mode  = 1'b0;
        start = 1'b1;
        advance();
        start = 1'b0;
        repeat (4) advance();       // step edge S: prescaler back to 0
        checks++;
        if (bcd !== 16'h0001 || tick !== 1'b1)
            $display("FAIL stop_first_step: got bcd=%h tick=%b expected 0001 1", bcd, tick);
        else passes++;
        advance();                  // S+1: prescaler 1
        advance();                  // S+2: prescaler 2
        stop = 1'b1;
        advance();                  // S+3: stop, prescaler holds 2
        stop = 1'b0;
        checks++;
        if (running !== 1'b0) $display("FAIL stop_running: got %b expected 0", running);
        else passes++;
        sawTick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            advance();
            if (tick !== 1'b0) sawTick = 1'b1;
        end
        checks++;
        if (bcd !== 16'h0001 || sawTick !== 1'b0)
            $display("FAIL stop_hold: got bcd=%h sawTick=%b expected 0001 0", bcd, sawTick);
        else passes++;
        start = 1'b1;
        advance();                  // R: resume, prescaler still 2
        start = 1'b0;
        advance();                  // R+1: prescaler 3
        checks++;
        if (tick !== 1'b0 || running !== 1'b1)
            $display("FAIL resume_early: got tick=%b run=%b expected 0 1", tick, running);
        else passes++;
        advance();                  // R+2: step
        checks++;
        if (tick !== 1'b1 || bcd !== 16'h0002)
            $display("FAIL resume_step: got tick=%b bcd=%h expected 1 0002", tick, bcd);
        else passes++;
        // stop on the very edge where the prescaler would expire
        clear = 1'b1;
        advance();
        clear = 1'b0;
        start = 1'b1;
        advance();
        start = 1'b0;
        repeat (3) advance();       // prescaler now 3
        stop = 1'b1;
        advance();
        stop = 1'b0;
        checks++;
        if (tick !== 1'b0 || bcd !== 16'h0000 || running !== 1'b0)
            $display("FAIL stop_at_expiry: got tick=%b bcd=%h run=%b expected 0 0000 0", tick, bcd, running);
        else passes++;
        start = 1'b1;
        advance();
        start = 1'b0;
        advance();
        checks++;
        if (tick !== 1'b1 || bcd !== 16'h0001)
            $display("FAIL resume_from_last: got tick=%b bcd=%h expected 1 0001", tick, bcd);
        else passes++;
        clear = 1'b1;
        advance();
        clear = 1'b0;
    endtask

    task automatic test_priority();
        load_bcd = 16'h0312;
        load     = 1'b1;
        advance();
        load     = 1'b0;
        clear    = 1'b1;
        start    = 1'b1;
        advance();
        clear    = 1'b0;
        start    = 1'b0;
        checks++;
        if (bcd !== 16'h0000 || running !== 1'b0)
            $display("FAIL clear_beats_start: got bcd=%h run=%b expected 0000 0", bcd, running);
        else passes++;
        load_bcd = 16'h0312;
        load     = 1'b1;
        advance();
        load_bcd = 16'h0A00;
        advance();
        load_bcd = 16'h6000;
        advance();
        load_bcd = 16'h0360;
        advance();
        load     = 1'b0;
        checks++;
        if (bcd !== 16'h0312)
            $display("FAIL invalid_load_ignored: got %h expected 0312", bcd);
        else passes++;
        load_bcd = 16'h5959;
        load     = 1'b1;
        advance();
        load     = 1'b0;
        checks++;
        if (bcd !== 16'h5959) $display("FAIL load_max_valid: got %h expected 5959", bcd);
        else passes++;
        load_bcd = 16'h0045;
        load     = 1'b1;
        start    = 1'b1;
        advance();
        load     = 1'b0;
        start    = 1'b0;
        checks++;
        if (bcd !== 16'h0045 || running !== 1'b0)
            $display("FAIL load_beats_start: got bcd=%h run=%b expected 0045 0", bcd, running);
        else passes++;
        start    = 1'b1;
        advance();
        start    = 1'b0;
        load_bcd = 16'h0A00;
        load     = 1'b1;
        advance();
        load     = 1'b0;
        checks++;
        if (running !== 1'b1 || bcd !== 16'h0045)
            $display("FAIL invalid_load_in_run: got run=%b bcd=%h expected 1 0045", running, bcd);
        else passes++;
        clear = 1'b1;
        advance();
        clear = 1'b0;
        mode  = 1'b1;
        start = 1'b1;
        advance();
        start = 1'b0;
        checks++;
        if (running !== 1'b0 || expired !== 1'b0)
            $display("FAIL zero_countdown_start: got run=%b exp=%b expected 0 0", running, expired);
        else passes++;
        mode = 1'b0;
    endtask

    task automatic test_reset_midrun();
        load_bcd = 16'h1233;
        load     = 1'b1;
        advance();
        load     = 1'b0;
        start    = 1'b1;
        advance();
        start    = 1'b0;
        repeat (4) advance();
        checks++;
        if (bcd !== 16'h1234 || tick !== 1'b1)
            $display("FAIL midrun_setup: got bcd=%h tick=%b expected 1234 1", bcd, tick);
        else passes++;
        repeat (3) advance();       // next edge would be a step
        rst_n = 1'b0;
        advance();
        checks++;
        if ({bcd, running, tick, wrap, done, expired} !== 21'd0)
            $display("FAIL midrun_reset: got bcd=%h run=%b tick=%b wrap=%b done=%b exp=%b expected all zero",
                     bcd, running, tick, wrap, done, expired);
        else passes++;
        rst_n = 1'b1;
        repeat (6) advance();
        checks++;
        if (running !== 1'b0 || bcd !== 16'h0000)
            $display("FAIL midrun_after_reset: got run=%b bcd=%h expected 0 0000", running, bcd);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_countdown();
        test_stop_resume();
        test_priority();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mmss_updown_timer.md
# mmss_updown_timer

Parametrised MM:SS timer for the Basys seven-segment display path. It counts up as a stopwatch or down as a countdown, in four BCD digits. It replaces rippled per-digit clocks with one clock domain and one prescaler-enable, and adds start/stop, preload, countdown-expiry and wrap signalling. The `bcd` output feeds the existing four-digit display driver directly (d3..d0).

## Interface
- `TICK_DIV`, default 100000000: clk cycles per count step (1 s at 100 MHz); must be ≥ 2.
- `MAX_MIN_TENS`, default 5: upper limit of the minutes-tens digit, 0..9; count range is 00:00 .. `MAX_MIN_TENS`9:59.

- `clk`  in  1  system clock; all logic on its rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `start`  in  1  one-cycle pulse: begin/resume counting
- `stop`  in  1  one-cycle pulse: pause counting
- `clear`  in  1  one-cycle pulse: zero count, go idle
- `load`  in  1  one-cycle pulse: preload count from `load_bcd`
- `load_bcd`  in  16  preload value {d3,d2,d1,d0}
- `mode`  in  1  0 = count up, 1 = count down
- `bcd`  out  16  current count {min tens, min ones, sec tens, sec ones}
- `running`  out  1  high in RUN state
- `tick`  out  1  one-cycle pulse on every count step
- `wrap`  out  1  one-cycle pulse when up-count rolls max → 00:00
- `done`  out  1  one-cycle pulse when down-count reaches 00:00
- `expired`  out  1  level, high in EXPIRED state

## Operation
- Reset (`rst_n` = 0 at an edge): `bcd` = 0, prescaler = 0, state IDLE, all pulse outputs 0, `running` = 0, `expired` = 0.
- States:
  - IDLE: the prescaler holds its value.
    - `start` → RUN, except when `mode` = 1 and `bcd` = 0, where `start` is ignored.
  - RUN: the prescaler increments each cycle. At `TICK_DIV`-1 it returns to 0 and a step occurs.
    - `stop` → IDLE, and the prescaler keeps its partial count (resume is exact).
  - EXPIRED: `bcd` holds 0000 and `start` is ignored.
    - `clear` or a valid `load` → IDLE.
- Command priority in a single cycle: `clear` > `load` > `stop` > `start` > step. A lower-priority event in the same cycle is discarded.
- `clear`: `bcd` = 0 and prescaler = 0, in any state; next state IDLE.
- `load`:
  - Accepted only if d0 ≤ 9, d1 ≤ 5, d2 ≤ 9 and d3 ≤ `MAX_MIN_TENS`. An invalid `load` is ignored entirely, with no state change.
  - An accepted `load` sets `bcd` = `load_bcd` and prescaler = 0; next state IDLE.
- Up step:
  - Each digit increments in BCD. Seconds-ones wraps 9→0 with carry; seconds-tens wraps 5→0 with carry; minutes-ones wraps 9→0 with carry.
  - At max (`MAX_MIN_TENS`9:59) the count goes to 00:00, `wrap` pulses, and the timer stays in RUN.
- Down step:
  - Each digit decrements in BCD with borrow: 0→9 for ones digits, seconds-tens 0→5.
  - When the result is 00:00, `done` pulses and the state goes to EXPIRED.
- `mode` is sampled at each step. A change while in RUN applies to the next step and the count is kept.
- All outputs are registered. Invalid internal digits are unreachable.

## Timing
- `start` high at edge N → `running` = 1 after edge N. With the prescaler at 0, the first step occurs at edge N+`TICK_DIV`.
- At a step edge, `bcd` updates and `tick` goes high for exactly one cycle. `wrap`/`done` are high in that same cycle.
- `expired` and `running` = 0 take effect at the same edge as `done`.
- `stop` at edge M: no step occurs at M even if the prescaler would have expired there; the prescaler holds `TICK_DIV`-1.
- `clear`/`load` take effect at the edge where they are sampled. `bcd` shows the new value in the next cycle.
- `rst_n` low during RUN overrides everything at that edge.

## Test plan
- `TICK_DIV`=4, reset, `mode`=0, `start` → `tick` every 4 cycles; `bcd` goes 0000, 0001 … 0009, 0010; reaches 0100 after 60 steps.
- `TICK_DIV`=4, `load` 5958 then `start`, `mode`=0 → steps show 5959, then 0000 with `wrap`=1 for one cycle; `running` stays 1.
- `mode`=1, `load` 0100, `start` → 0059, 0058 … 0001, 0000. `done` pulses with 0000; `expired`=1; `running`=0; a later `start` is ignored; `clear` returns to IDLE.
- `stop` 2 cycles after a step, wait 20 cycles, then `start` → the next step comes exactly 2 cycles after restart; `bcd` is unchanged while stopped.
- Priority: `clear`+`start` same cycle → `bcd`=0000, IDLE. Invalid `load` 0A00 → ignored. `mode`=1, `bcd`=0, `start` → stays IDLE.
- `rst_n` low mid-RUN at `bcd`=1234 → next cycle `bcd`=0, `running`=0, all pulses 0.
